// File: rtl/bus_coherence_ctrl_if.sv
// bus_coherence_ctrl_if: dcache, snoop and RAM signals between two dcaches, the coherence controller and RAM
interface bus_coherence_ctrl_if;
  logic [1:0] dREN, dWEN, snoopdirty, dwait, ccwait, ccwrite;
  logic [1:0][31:0] daddr, dstore, ccsnoopaddr;
  logic [31:0] dload, ramaddr, ramstore, ramload;
  logic ramREN, ramWEN;
  logic [1:0] ramstate;
  modport master (
    input dREN, dWEN, daddr, dstore, snoopdirty, ramload, ramstate,
    output dwait, dload, ccwait, ccwrite, ccsnoopaddr, ramREN, ramWEN, ramaddr, ramstore
  );
  modport slave (
    output dREN, dWEN, daddr, dstore, snoopdirty, ramload, ramstate,
    input dwait, dload, ccwait, ccwrite, ccsnoopaddr, ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/bus_coherence_ctrl.sv
// bus_coherence_ctrl: two-core snooping arbiter; snoops the other dcache on read misses and forces dirty writebacks
module bus_coherence_ctrl (
  input logic CLK,
  input logic nRST,
  bus_coherence_ctrl_if.master bus
);
  typedef enum logic [1:0] {IDLE, SNOOP, SNWB, XFER} state_t;
  state_t state, state_n;
  logic owner, owner_n, lastgrant, lastgrant_n, snooped, snooped_n, wbcount, wbcount_n;
  logic other, access;
  logic [1:0] req, dwait, ccwait, ccwrite;
  logic [1:0][31:0] ccsnoopaddr;
  logic ram_ren, ram_wen;
  logic [31:0] ram_addr, ram_store;
  assign req = bus.dREN | bus.dWEN;
  assign other = ~owner;
  assign access = bus.ramstate == 2'd2;
  assign bus.dload = bus.ramload;
  assign bus.dwait = dwait;
  assign bus.ccwait = ccwait;
  assign bus.ccwrite = ccwrite;
  assign bus.ccsnoopaddr = ccsnoopaddr;
  assign bus.ramREN = ram_ren;
  assign bus.ramWEN = ram_wen;
  assign bus.ramaddr = ram_addr;
  assign bus.ramstore = ram_store;
  // state, grant and snoop bookkeeping registers
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      owner <= 1'b0;
      lastgrant <= 1'b1;
      snooped <= 1'b0;
      wbcount <= 1'b0;
    end else begin
      state <= state_n;
      owner <= owner_n;
      lastgrant <= lastgrant_n;
      snooped <= snooped_n;
      wbcount <= wbcount_n;
    end
  end
  // arbitration, snoop sequencing and RAM routing; every output decoded from state
  always_comb begin
    state_n = state;
    owner_n = owner;
    lastgrant_n = lastgrant;
    snooped_n = snooped;
    wbcount_n = wbcount;
    dwait = 2'b11;
    ccwait = 2'b00;
    ccwrite = 2'b00;
    ccsnoopaddr = '0;
    ram_ren = 1'b0;
    ram_wen = 1'b0;
    ram_addr = '0;
    ram_store = '0;
    case (state)
      IDLE: begin
        snooped_n = 1'b0;
        wbcount_n = 1'b0;
        if (|req) begin
          owner_n = req == 2'b01 ? 1'b0 : req == 2'b10 ? 1'b1 : ~lastgrant;
          state_n = bus.dREN[owner_n] & ~bus.dWEN[owner_n] ? SNOOP : XFER;
        end
      end
      SNOOP: begin
        ccwait[other] = 1'b1;
        ccsnoopaddr[other] = bus.daddr[owner];
        snooped_n = 1'b1;
        state_n = bus.snoopdirty[other] ? SNWB : XFER;
      end
      SNWB: begin
        ccwait[other] = 1'b1;
        ccwrite[other] = 1'b1;
        ram_wen = bus.dWEN[other];
        ram_addr = bus.daddr[other];
        ram_store = bus.dstore[other];
        dwait[other] = ~access;
        if (access) begin
          wbcount_n = ~wbcount;
          state_n = wbcount ? XFER : SNWB;
        end
      end
      XFER: begin
        if (bus.dREN[owner] & ~bus.dWEN[owner] & ~snooped) begin
          state_n = SNOOP;
        end else if (!req[owner]) begin
          state_n = IDLE;
          lastgrant_n = owner;
        end else begin
          ram_ren = bus.dREN[owner] & ~bus.dWEN[owner];
          ram_wen = bus.dWEN[owner];
          ram_addr = bus.daddr[owner];
          ram_store = bus.dstore[owner];
          dwait[owner] = ~access;
        end
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_bus_coherence_ctrl.sv
// tb_bus_coherence_ctrl: directed and randomized checks of the coherence controller against a word-level memory model
module tb_bus_coherence_ctrl;
  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;
  logic CLK = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;
  bus_coherence_ctrl_if bif();
  bus_coherence_ctrl dut (.CLK(CLK), .nRST(nRST), .bus(bif.master));
  int total = 0, passed = 0, fails = 0;
  logic [31:0] mem [logic [31:0]];
  logic [31:0] refm [logic [31:0]];
  int n [2], k [2], wk [2];
  logic op_we [2][4];
  logic [31:0] op_a [2][4], op_d [2][4];
  logic dv [2], wbm [2];
  logic [31:0] dbase [2];
  logic [31:0] dd [2][2];
  int rs_mode, last_done, first_done, exp_w, mask;
  logic [1:0] rs_dir;
  logic [31:0] base;

  function automatic logic [31:0] init_val(logic [31:0] a);
    return a ^ 32'h5a5a_0000;
  endfunction
  function automatic logic [31:0] mrd(logic [31:0] a);
    return mem.exists(a) ? mem[a] : init_val(a);
  endfunction
  function automatic logic [31:0] rrd(logic [31:0] a);
    return refm.exists(a) ? refm[a] : init_val(a);
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // cache agents drive, snoop responses and the RAM answer settle, then sample at the falling edge
  task automatic settle();
    @(posedge CLK);
    #1;
    for (int i = 0; i < 2; i++) begin
      int kk;
      logic act;
      kk = k[i] < n[i] ? k[i] : 0;
      wbm[i] = bif.ccwait[i] && bif.ccwrite[i] && dv[i];
      act = k[i] < n[i] && !wbm[i];
      bif.dREN[i] = act && !op_we[i][kk];
      bif.dWEN[i] = wbm[i] || (act && op_we[i][kk]);
      bif.daddr[i] = wbm[i] ? dbase[i] + 32'(4 * wk[i]) : act ? op_a[i][kk] : 32'h0;
      bif.dstore[i] = wbm[i] ? dd[i][wk[i]] : act ? op_d[i][kk] : 32'h0;
    end
    #1;
    for (int i = 0; i < 2; i++)
      bif.snoopdirty[i] = bif.ccwait[i] && dv[i] && bif.ccsnoopaddr[i] == dbase[i];
    if (!(bif.ramREN || bif.ramWEN)) bif.ramstate = FREE;
    else if (rs_mode == 0) bif.ramstate = ACCESS;
    else if (rs_mode == 2) bif.ramstate = rs_dir;
    else begin
      int r;
      r = $urandom_range(0, 9);
      bif.ramstate = r < 6 ? ACCESS : r < 9 ? BUSY : ERROR;
    end
    bif.ramload = mrd(bif.ramaddr);
    @(negedge CLK);
  endtask

  // RAM write and agent progress for the cycle just sampled
  task automatic commit();
    if (bif.ramWEN && bif.ramstate == ACCESS) mem[bif.ramaddr] = bif.ramstore;
    for (int i = 0; i < 2; i++) begin
      if (!bif.dwait[i]) begin
        if (wbm[i]) begin
          chk("wb_addr", bif.ramaddr, dbase[i] + 32'(4 * wk[i]));
          chk("wb_wen", bif.ramWEN, 1);
          refm[dbase[i] + 32'(4 * wk[i])] = dd[i][wk[i]];
          wk[i]++;
          if (wk[i] == 2) begin
            dv[i] = 1'b0;
            wk[i] = 0;
          end
        end else if (k[i] < n[i]) begin
          chk("xfer_addr", bif.ramaddr, op_a[i][k[i]]);
          if (op_we[i][k[i]]) begin
            chk("xfer_wen", bif.ramWEN, 1);
            refm[op_a[i][k[i]]] = op_d[i][k[i]];
          end else begin
            chk("xfer_ren", bif.ramREN, 1);
            chk("rdata", bif.dload, rrd(op_a[i][k[i]]));
          end
          k[i]++;
          if (k[i] == n[i]) begin
            if (first_done < 0) first_done = i;
            last_done = i;
          end
        end else chk("spurious_dwait", bif.dwait[i], 1);
      end
    end
  endtask

  task automatic next();
    commit();
    settle();
  endtask

  task automatic blk(int i, logic we, logic [31:0] a);
    for (int w = 0; w < 2; w++) begin
      op_we[i][n[i]] = we;
      op_a[i][n[i]] = a + 32'(4 * w);
      op_d[i][n[i]] = we ? $urandom : 32'h0;
      n[i]++;
    end
  endtask

  task automatic clear_agents();
    for (int i = 0; i < 2; i++) begin
      n[i] = 0;
      k[i] = 0;
      wk[i] = 0;
      dv[i] = 1'b0;
      wbm[i] = 1'b0;
    end
  endtask

  task automatic make_dirty(int i, logic [31:0] a);
    dv[i] = 1'b1;
    dbase[i] = a;
    dd[i][0] = $urandom;
    dd[i][1] = $urandom;
  endtask

  task automatic drain();
    int c;
    c = 0;
    while ((k[0] < n[0] || k[1] < n[1] || dv[0] || dv[1]) && c < 400) begin
      next();
      c++;
      chk("dwait_excl", bif.dwait != 2'b00, 1);
      chk("ccwrite_in_ccwait", bif.ccwrite & ~bif.ccwait, 0);
      chk("strobe_excl", bif.ramREN && bif.ramWEN, 0);
    end
    chk("drain_timeout", c < 400, 1);
    clear_agents();
    next();
    next();
  endtask

  task automatic chk_idle_outputs(string tag);
    chk({tag, "_dwait"}, bif.dwait, 2'b11);
    chk({tag, "_ccwait"}, bif.ccwait, 0);
    chk({tag, "_ccwrite"}, bif.ccwrite, 0);
    chk({tag, "_ramREN"}, bif.ramREN, 0);
    chk({tag, "_ramWEN"}, bif.ramWEN, 0);
  endtask

  initial begin
    clear_agents();
    rs_mode = 0;
    rs_dir = ACCESS;
    last_done = 1;
    first_done = -1;
    bif.dREN = 2'b00;
    bif.dWEN = 2'b00;
    bif.daddr = '0;
    bif.dstore = '0;
    bif.snoopdirty = 2'b00;
    bif.ramload = 32'h0;
    bif.ramstate = FREE;
    repeat (2) settle();
    chk_idle_outputs("reset");
    chk("reset_ramaddr", bif.ramaddr, 0);
    chk("reset_ramstore", bif.ramstore, 0);
    chk("reset_snoopaddr", bif.ccsnoopaddr, 0);
    nRST = 1'b1;
    settle();
    chk_idle_outputs("post_reset");
    // first tie after reset goes to core 0
    blk(0, 1'b1, 32'h700);
    blk(1, 1'b1, 32'h800);
    next();
    chk("tie1_c0_dwait", bif.dwait, 2'b11);
    next();
    chk("tie1_wen", bif.ramWEN, 1);
    chk("tie1_addr", bif.ramaddr, 32'h700);
    drain();
    blk(0, 1'b1, 32'h710);
    drain();
    // core 0 was the last released, so core 1 takes the next tie
    blk(0, 1'b1, 32'h720);
    blk(1, 1'b1, 32'h820);
    next();
    next();
    chk("tie2_addr", bif.ramaddr, 32'h820);
    drain();
    // clean read by core 0
    blk(0, 1'b0, 32'h100);
    next();
    chk("rd_c0_dwait", bif.dwait, 2'b11);
    chk("rd_c0_ren", bif.ramREN, 0);
    next();
    chk("rd_c1_ccwait", bif.ccwait, 2'b10);
    chk("rd_c1_snoop1", bif.ccsnoopaddr[1], 32'h100);
    chk("rd_c1_snoop0", bif.ccsnoopaddr[0], 0);
    chk("rd_c1_ren", bif.ramREN, 0);
    next();
    chk("rd_c2_ren", bif.ramREN, 1);
    chk("rd_c2_addr", bif.ramaddr, 32'h100);
    chk("rd_c2_dwait", bif.dwait, 2'b10);
    next();
    chk("rd_c3_addr", bif.ramaddr, 32'h104);
    chk("rd_c3_dwait", bif.dwait, 2'b10);
    next();
    chk("rd_c4_dwait", bif.dwait, 2'b11);
    chk("rd_c4_ren", bif.ramREN, 0);
    next();
    chk_idle_outputs("rd_c5");
    drain();
    // core 1 read while core 0 holds the line dirty
    make_dirty(0, 32'h200);
    blk(1, 1'b0, 32'h200);
    next();
    next();
    chk("dirty_c1_ccwait", bif.ccwait, 2'b01);
    chk("dirty_c1_snoop0", bif.ccsnoopaddr[0], 32'h200);
    next();
    chk("dirty_c2_ccwait", bif.ccwait, 2'b01);
    chk("dirty_c2_ccwrite", bif.ccwrite, 2'b01);
    chk("dirty_c2_wen", bif.ramWEN, 1);
    chk("dirty_c2_addr", bif.ramaddr, 32'h200);
    chk("dirty_c2_store", bif.ramstore, dd[0][0]);
    chk("dirty_c2_dwait", bif.dwait, 2'b10);
    next();
    chk("dirty_c3_addr", bif.ramaddr, 32'h204);
    chk("dirty_c3_store", bif.ramstore, dd[0][1]);
    next();
    chk("dirty_c4_ren", bif.ramREN, 1);
    chk("dirty_c4_addr", bif.ramaddr, 32'h200);
    chk("dirty_c4_ccwait", bif.ccwait, 0);
    chk("dirty_c4_dwait", bif.dwait, 2'b01);
    drain();
    // writeback then refill with no gap
    blk(0, 1'b1, 32'h300);
    blk(0, 1'b0, 32'h400);
    next();
    next();
    chk("wbrf_c1_wen", bif.ramWEN, 1);
    chk("wbrf_c1_addr", bif.ramaddr, 32'h300);
    next();
    chk("wbrf_c2_addr", bif.ramaddr, 32'h304);
    next();
    chk("wbrf_c3_ren", bif.ramREN, 0);
    chk("wbrf_c3_wen", bif.ramWEN, 0);
    chk("wbrf_c3_dwait", bif.dwait, 2'b11);
    next();
    chk("wbrf_c4_ccwait", bif.ccwait, 2'b10);
    chk("wbrf_c4_snoop1", bif.ccsnoopaddr[1], 32'h400);
    next();
    chk("wbrf_c5_ren", bif.ramREN, 1);
    chk("wbrf_c5_addr", bif.ramaddr, 32'h400);
    drain();
    // RAM busy (and one error cycle) before the word completes
    rs_mode = 2;
    rs_dir = BUSY;
    blk(1, 1'b1, 32'h500);
    next();
    for (int c = 1; c <= 3; c++) begin
      rs_dir = c == 3 ? ERROR : BUSY;
      next();
      chk("busy_dwait", bif.dwait, 2'b11);
      chk("busy_addr", bif.ramaddr, 32'h500);
      chk("busy_wen", bif.ramWEN, 1);
    end
    rs_dir = ACCESS;
    next();
    chk("busy_done_dwait", bif.dwait, 2'b01);
    chk("busy_done_addr", bif.ramaddr, 32'h500);
    drain();
    rs_mode = 0;
    // reset in the middle of a forced writeback
    make_dirty(0, 32'h600);
    blk(1, 1'b0, 32'h600);
    next();
    next();
    next();
    chk("rst_pre_ccwrite", bif.ccwrite, 2'b01);
    nRST = 1'b0;
    clear_agents();
    #1;
    chk_idle_outputs("rst_async");
    next();
    chk_idle_outputs("rst_next");
    nRST = 1'b1;
    last_done = 1;
    next();
    blk(0, 1'b1, 32'h740);
    blk(1, 1'b1, 32'h840);
    next();
    next();
    chk("rst_tie_addr", bif.ramaddr, 32'h740);
    drain();
    // randomized traffic with random RAM latency
    rs_mode = 1;
    for (int it = 0; it < 40; it++) begin
      mask = $urandom_range(1, 3);
      first_done = -1;
      exp_w = 1 - last_done;
      for (int i = 0; i < 2; i++) begin
        if (mask[i]) begin
          base = (i == 1 ? 32'h2000 : 32'h1000) + 32'(8 * $urandom_range(0, 3));
          if ($urandom_range(0, 1) == 1) blk(i, 1'b1, base);
          else begin
            blk(i, 1'b0, base);
            if ($urandom_range(0, 1) == 1) make_dirty(1 - i, base);
          end
        end
      end
      next();
      drain();
      if (mask == 3) chk("rr_winner", first_done, exp_w);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/bus_coherence_ctrl.md
# bus_coherence_ctrl

Two-core snooping bus controller sitting directly below the per-core data-cache control units and above the single-ported RAM. It arbitrates word-level dREN/dWEN traffic from two dcaches onto one RAM port and snoops the other cache on every read miss. When the other cache holds the line dirty, the controller forces it to write back and invalidate (ccwait+ccwrite) before the requester's read reaches RAM.

## Interface
- No parameters.
- CLK  in  1  clock, rising edge.
- nRST  in  1  asynchronous, active-low reset.
- dREN  in  2  per-cache word read request (index = core).
- dWEN  in  2  per-cache word write request.
- daddr  in  2x32  per-cache word address.
- dstore  in  2x32  per-cache write data.
- snoopdirty  in  2  cache i reports that ccsnoopaddr[i] hits a dirty line; combinational, valid while ccwait[i].
- dwait  out  2  per-cache stall; low for exactly the cycle its word completes.
- dload  out  32  RAM read data, broadcast to both caches.
- ccwait  out  2  snoop/coherence stall to cache i.
- ccwrite  out  2  with ccwait: cache i must write back and invalidate the snooped line.
- ccsnoopaddr  out  2x32  address being snooped in cache i.
- ramREN, ramWEN  out  1  RAM strobes.
- ramaddr, ramstore  out  32  RAM address/data.
- ramload  in  32  RAM read data.
- ramstate  in  2  FREE=0, BUSY=1, ACCESS=2, ERROR=3; a word completes when ramstate==ACCESS.

## Operation
- req[i] = dREN[i] | dWEN[i]. Registered state: FSM state, owner (1b), lastgrant (1b), snooped (1b), wbcount (1b).
- States: IDLE, SNOOP, SNWB, XFER. "Other" = ~owner.
- IDLE: no RAM strobes, both dwait=1. If only one req, owner := that core. If both, owner := ~lastgrant (round robin). Clear snooped. Next state: SNOOP if owner has dREN & ~dWEN, else XFER.
- SNOOP (exactly 1 cycle): ccwait[other]=1, ccsnoopaddr[other]=daddr[owner], snooped := 1. If snoopdirty[other]=1, go to SNWB, else go to XFER.
- SNWB: ccwait[other]=1, ccwrite[other]=1. Pass through the other cache's dWEN/daddr/dstore to RAM; dwait[other] = ~(ramstate==ACCESS). wbcount increments on each completed word; after the 2nd completion (wbcount wraps 1→0), go to XFER. dwait[owner]=1 throughout.
- XFER: pass through the owner's dREN/dWEN/daddr/dstore to RAM; dwait[owner] = ~(ramstate==ACCESS).
  - If dREN[owner]=1, dWEN[owner]=0 and snooped=0 (writeback followed by refill), go to SNOOP. No RAM strobe and dwait[owner]=1 that cycle.
  - If req[owner]=0, go to IDLE and set lastgrant := owner.
- If owner drives both dREN and dWEN, the write wins: ramWEN only.
- The non-owner's dwait is always 1, except during SNWB as above.
- ramstate ERROR is treated as BUSY: no completion, hold state.
- ccsnoopaddr[i] = 0 when not snooping cache i.

## Timing
- Reset values: state=IDLE, owner=0, lastgrant=1 (core 0 wins the first tie), snooped=0, wbcount=0. All outputs are combinational from state, so during and after reset: dwait=2'b11, ccwait=ccwrite=0, ramREN=ramWEN=0, ramaddr=ramstore=0, ccsnoopaddr=0.
- Write grant: request seen in IDLE at cycle 0; ramWEN asserted at cycle 1.
- Read grant, clean snoop: SNOOP at cycle 1; ramREN at cycle 2.
- Read grant, dirty snoop: 1 + 1 + 2 writeback words before ramREN.
- A completed word ends dwait low for that cycle only. The cache advances its address; the controller holds the grant.
- The grant is released only after the owner drops req; the earliest re-arbitration is the following cycle.
- Reset mid-transfer: immediate return to IDLE and all strobes deasserted. A partial RAM word is abandoned.

## Test plan
- Core 0 read of 0x100, snoopdirty=0, RAM ACCESS every cycle -> SNOOP at cycle 1 with ccsnoopaddr[1]=0x100; ramREN at cycle 2; dwait[0] low at cycles 2 and 3 (addresses 0x100, 0x104); IDLE after dREN drops.
- Core 1 read of 0x200, core 0 snoopdirty=1 -> ccwait[0]=ccwrite[0]=1; core 0 writes 0x200 and 0x204 to RAM; then core 1 ramREN 0x200; dwait[1] stays high until then.
- Both cores request in IDLE right after reset -> core 0 granted first. Next tie -> core 1 granted.
- Core 0 writeback 0x300/0x304, then dREN 0x400 with no gap -> two RAM writes, then one SNOOP cycle for 0x400, then RAM reads.
- ramstate=BUSY for 3 cycles, then ACCESS -> dwait[owner] low only on the ACCESS cycle; ramaddr stable throughout.
- nRST asserted during SNWB -> next cycle: all ccwait/ccwrite/ram strobes 0, dwait=2'b11, state IDLE.
